// File: rtl/dsp16_word_tx.sv
// dsp16_word_tx: queues 16-bit DSP result words and streams each one out of the
// serial pin as three 8N1 bytes (SYNC, high byte, low byte) at BAUD clocks per bit.
module dsp16_word_tx #(
   parameter int unsigned BAUD  = 104,
   parameter int unsigned DEPTH = 4,
   parameter logic [7:0]  SYNC  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        tx,
   output logic        busy,
   output logic        overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(BAUD);
   localparam logic [CW-1:0] BIT_LAST = CW'(BAUD - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StData,
      StStop
   } state_e;

   // Word FIFO
   logic [15:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic [15:0] head;

   // Transmit FSM
   state_e        state_q;
   state_e        state_d;
   logic [15:0]   word_q;
   logic [15:0]   word_d;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;
   logic [1:0]    byte_idx_q;
   logic [1:0]    byte_idx_d;
   logic [2:0]    bit_idx_q;
   logic [2:0]    bit_idx_d;
   logic [CW-1:0] baud_cnt_q;
   logic [CW-1:0] baud_cnt_d;
   logic          tx_q;
   logic          tx_d;
   logic          bit_done;

   // Extra wrap bit on the pointers distinguishes full from empty
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push      = din_valid & ~full;
   assign head      = mem_q[rd_ptr_q[AW-1:0]];
   assign bit_done  = (baud_cnt_q == BIT_LAST);

   assign din_ready = ~full;
   assign overflow  = din_valid & full;
   assign busy      = (state_q != StIdle) | ~empty;
   assign tx        = tx_q;

   // Word storage; contents are only ever read behind the pointers, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   // FIFO pointers; push and pop in the same cycle both take effect
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // FSM and datapath registers; tx resets to the idle (mark) level
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         word_q     <= '0;
         shift_q    <= '0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         baud_cnt_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         baud_cnt_q <= baud_cnt_d;
         tx_q       <= tx_d;
      end
   end

   // Next-state logic: byte sequencing, bit timing and FIFO pop requests
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      shift_d    = shift_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      baud_cnt_d = baud_cnt_q;
      pop        = 1'b0;

      unique case (state_q)
         StIdle: begin
            baud_cnt_d = '0;
            if (!empty) begin
               pop        = 1'b1;
               word_d     = head;
               byte_idx_d = 2'd0;
               state_d    = StLoad;
            end
         end

         StLoad: begin
            case (byte_idx_q)
               2'd0:    shift_d = SYNC;
               2'd1:    shift_d = word_q[15:8];
               default: shift_d = word_q[7:0];
            endcase
            baud_cnt_d = '0;
            state_d    = StStart;
         end

         StStart: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               bit_idx_d  = 3'd0;
               state_d    = StData;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         StData: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               shift_d    = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         StStop: begin
            if (bit_done) begin
               baud_cnt_d = '0;
               if (byte_idx_q < 2'd2) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  state_d    = StLoad;
               end else if (!empty) begin
                  // Next word follows immediately; only its LOAD cycle separates the frames
                  pop        = 1'b1;
                  word_d     = head;
                  byte_idx_d = 2'd0;
                  state_d    = StLoad;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Pin level follows the state being entered, so the registered tx lines up with the FSM
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_dsp16_word_tx.sv
// Bench for dsp16_word_tx: a fast instance (BAUD=4) and a default-rate instance (BAUD=104)
// are compared cycle by cycle against a frame-arithmetic reference model, and a UART
// receiver model decodes the serial line.
module tb_dsp16_word_tx;

   localparam int unsigned FAST_BAUD = 4;
   localparam int unsigned SLOW_BAUD = 104;
   localparam int unsigned DEPTH     = 4;
   localparam logic [7:0]  SYNC      = 8'hA5;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic        dv_f;
   logic        dv_s;
   logic        rdy_f, tx_f, busy_f, ovf_f;
   logic        rdy_s, tx_s, busy_s, ovf_s;

   always #5 clk = ~clk;

   dsp16_word_tx #(
      .BAUD  (FAST_BAUD),
      .DEPTH (DEPTH),
      .SYNC  (SYNC)
   ) u_dut_fast (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (dv_f),
      .din_ready (rdy_f),
      .tx        (tx_f),
      .busy      (busy_f),
      .overflow  (ovf_f)
   );

   dsp16_word_tx #(
      .BAUD  (SLOW_BAUD),
      .DEPTH (DEPTH),
      .SYNC  (SYNC)
   ) u_dut_slow (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (dv_s),
      .din_ready (rdy_s),
      .tx        (tx_s),
      .busy      (busy_s),
      .overflow  (ovf_s)
   );

   // Which instance is under test
   bit   use_slow;
   logic o_tx, o_busy, o_rdy, o_ovf;
   always_comb begin
      o_tx   = use_slow ? tx_s   : tx_f;
      o_busy = use_slow ? busy_s : busy_f;
      o_rdy  = use_slow ? rdy_s  : rdy_f;
      o_ovf  = use_slow ? ovf_s  : ovf_f;
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: queued words, word on the wire, cycles left in its frame
   int          m_baud;
   logic [15:0] m_q[$];
   logic [15:0] m_cur;
   int          m_left = 0;
   logic [7:0]  rx_exp[$];
   int          n_acc = 0;
   int          cyc = 0;
   int          ovf_seen = 0;
   logic        prev_busy = 1'b0;
   int          fall_cyc = -1;

   function automatic int byte_len();
      return 10 * m_baud + 1;
   endfunction

   function automatic int frame_len();
      return 3 * byte_len();
   endfunction

   // Each byte slot: 1 LOAD cycle at mark, start, 8 data bits LSB first, stop
   function automatic logic exp_tx();
      int pos, k, w, b;
      logic [7:0] byt;
      if (m_left == 0) return 1'b1;
      pos = frame_len() - m_left;
      k   = pos / byte_len();
      w   = pos % byte_len();
      if (w == 0) return 1'b1;
      b = (w - 1) / m_baud;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      byt = (k == 0) ? SYNC : (k == 1) ? m_cur[15:8] : m_cur[7:0];
      return byt[b-1];
   endfunction

   task automatic model_step(input logic v, input logic [15:0] d, input logic r);
      bit pop, acc;
      if (r) begin
         m_q.delete();
         rx_exp.delete();
         m_left = 0;
         return;
      end
      pop = (m_q.size() > 0) && (m_left <= 1);
      acc = v && (m_q.size() < DEPTH);
      if (pop) begin
         m_cur  = m_q.pop_front();
         m_left = frame_len();
         rx_exp.push_back(SYNC);
         rx_exp.push_back(m_cur[15:8]);
         rx_exp.push_back(m_cur[7:0]);
      end else if (m_left > 0) begin
         m_left--;
      end
      if (acc) begin
         m_q.push_back(d);
         n_acc++;
      end
   endtask

   // One clock: drive just after posedge, check on negedge, advance the model
   task automatic step(input logic v, input logic [15:0] d, input logic r);
      rst  = r;
      din  = d;
      dv_f = v & ~use_slow;
      dv_s = v & use_slow;
      @(negedge clk);
      check_eq("tx", o_tx, exp_tx());
      check_eq("busy", o_busy, (m_left > 0) || (m_q.size() > 0));
      check_eq("din_ready", o_rdy, m_q.size() < DEPTH);
      check_eq("overflow", o_ovf, v && (m_q.size() == DEPTH));
      if (o_ovf === 1'b1) ovf_seen++;
      if (prev_busy === 1'b1 && o_busy === 1'b0) fall_cyc = cyc;
      prev_busy = o_busy;
      model_step(v, d, r);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
   endtask

   task automatic drain();
      int guard = 0;
      while (((m_left > 0) || (m_q.size() > 0)) && guard < 20000) begin
         step(1'b0, 16'h0, 1'b0);
         guard++;
      end
      if (guard >= 20000) check_eq("drain_bound", o_busy, 1'b0);
      idle(3);
   endtask

   // UART receiver model: sample mid-bit, check framing and byte order
   bit         rx_on = 1'b0;
   logic       rx_prev = 1'b1;
   int         rx_cnt;
   int         rx_j;
   logic [7:0] rx_byte;
   logic [8:0] rx_want;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         rx_on   = 1'b0;
         rx_prev = 1'b1;
      end else begin
         if (!rx_on) begin
            if (rx_prev === 1'b1 && o_tx === 1'b0) begin
               rx_on  = 1'b1;
               rx_cnt = 0;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt % m_baud == m_baud / 2) begin
               rx_j = rx_cnt / m_baud;
               if (rx_j == 0) begin
                  check_eq("rx_start_bit", o_tx, 1'b0);
               end else if (rx_j <= 8) begin
                  rx_byte[rx_j-1] = o_tx;
               end else begin
                  check_eq("rx_stop_bit", o_tx, 1'b1);
                  rx_want = (rx_exp.size() > 0) ? {1'b0, rx_exp.pop_front()} : 9'h1ff;
                  check_eq("rx_byte", {1'b0, rx_byte}, rx_want);
                  rx_on = 1'b0;
               end
            end
         end
         rx_prev = o_tx;
      end
   end

   logic [15:0] burst[7] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                             16'h5555, 16'h6666, 16'h7777};
   logic [15:0] b2b[4]   = '{16'h0001, 16'h00FF, 16'hFF00, 16'hBEEF};

   initial begin
      int t_push, guard, rate, pos, w;
      rst      = 1'b1;
      din      = '0;
      dv_f     = 1'b0;
      dv_s     = 1'b0;
      use_slow = 1'b1;
      m_baud   = SLOW_BAUD;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state of both instances
      check_eq("reset_tx_fast", tx_f, 1'b1);
      check_eq("reset_busy_fast", busy_f, 1'b0);
      check_eq("reset_ready_fast", rdy_f, 1'b1);
      check_eq("reset_ovf_fast", ovf_f, 1'b0);
      check_eq("reset_tx_slow", tx_s, 1'b1);
      check_eq("reset_busy_slow", busy_s, 1'b0);

      // One word at BAUD=104; busy falls F+2 cycles after the push cycle
      idle(2);
      t_push = cyc;
      step(1'b1, 16'h1234, 1'b0);
      drain();
      check_eq("busy_fall_latency", fall_cyc - t_push, frame_len() + 2);

      // Switch to the fast instance
      step(1'b0, 16'h0, 1'b1);
      use_slow = 1'b0;
      m_baud   = FAST_BAUD;
      idle(2);

      // Back-to-back words
      for (int i = 0; i < 4; i++) step(1'b1, b2b[i], 1'b0);
      drain();

      // Burst of 7: one pops at once, four fill the FIFO, two are rejected
      ovf_seen = 0;
      for (int i = 0; i < 7; i++) step(1'b1, burst[i], 1'b0);
      check_eq("burst_overflows", ovf_seen, 2);
      check_eq("burst_ready_low", o_rdy, 1'b0);

      // Push in the very cycle the FSM pops, with three words queued
      guard = 0;
      while (!(m_q.size() == 3 && m_left == 1) && guard < 5000) begin
         step(1'b0, 16'h0, 1'b0);
         guard++;
      end
      if (guard >= 5000) check_eq("pushpop_bound", o_busy, 1'b0);
      ovf_seen = 0;
      step(1'b1, 16'hC0DE, 1'b0);
      check_eq("pushpop_no_ovf", ovf_seen, 0);
      check_eq("pushpop_ready", o_rdy, 1'b1);
      drain();

      // Reset during data bit 3 of the third byte
      step(1'b1, 16'hBEEF, 1'b0);
      guard = 0;
      forever begin
         if (m_left > 0) begin
            pos = frame_len() - m_left;
            w   = pos % byte_len();
            if (pos / byte_len() == 2 && w > 0 && (w - 1) / m_baud == 4) break;
         end
         if (guard >= 5000) break;
         step(1'b0, 16'h0, 1'b0);
         guard++;
      end
      if (guard >= 5000) check_eq("reset_point_bound", o_busy, 1'b0);
      step(1'b0, 16'h0, 1'b1);
      check_eq("midrst_tx", o_tx, 1'b1);
      check_eq("midrst_busy", o_busy, 1'b0);
      check_eq("midrst_ready", o_rdy, 1'b1);
      idle(3 * FAST_BAUD);
      step(1'b1, 16'h5A3C, 1'b0);
      drain();

      // Random traffic: 256 accepted words at varying offered load
      n_acc = 0;
      guard = 0;
      rate  = 10;
      while (n_acc < 256 && guard < 60000) begin
         if (guard % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       rate = 1;
               1:       rate = 8;
               default: rate = 60;
            endcase
         end
         step($urandom_range(0, 99) < rate, 16'($urandom), 1'b0);
         guard++;
      end
      if (n_acc < 256) check_eq("random_budget", n_acc, 256);
      drain();
      check_eq("rx_pending", rx_exp.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
